// File: rtl/fuzzify_sched.sv
// rtl/fuzzify_sched.sv - fuzzification sequencer sharing one trapezoid across all terms
//
// Holds trapezoid breakpoints (a,b,c,d) for every (input, set) term and, on
// start, sweeps all terms one per cycle through an external combinational
// trapezoid, streaming each Q15 membership degree with its term index.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_we, cfg_addr          table write strobe and term index
//   cfg_a..cfg_d              signed breakpoints of the written entry
//   cfg_drop                  one-cycle pulse when a write is rejected
//   start, x_vec              begin a sweep, packed signed crisp inputs
//   busy                      sweep in progress (RUN or DONE)
//   tz_x, tz_a..tz_d          drive to the shared trapezoid
//   tz_mu                     Q15 result from the shared trapezoid
//   mu_valid, mu_idx, mu_data registered membership stream
//   done                      one-cycle pulse at sweep completion
module fuzzify_sched #(
  parameter int N_IN  = 2,
  parameter int N_SET = 3,
  localparam int N_TERM = N_IN * N_SET,
  localparam int AW     = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic signed [7:0]     cfg_a,
  input  logic signed [7:0]     cfg_b,
  input  logic signed [7:0]     cfg_c,
  input  logic signed [7:0]     cfg_d,
  output logic                  cfg_drop,
  input  logic                  start,
  input  logic [N_IN*8-1:0]     x_vec,
  output logic                  busy,
  output logic signed [7:0]     tz_x,
  output logic signed [7:0]     tz_a,
  output logic signed [7:0]     tz_b,
  output logic signed [7:0]     tz_c,
  output logic signed [7:0]     tz_d,
  input  logic [15:0]           tz_mu,
  output logic                  mu_valid,
  output logic [AW-1:0]         mu_idx,
  output logic [15:0]           mu_data,
  output logic                  done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SW = (N_SET > 1) ? $clog2(N_SET) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [IW-1:0]     in_cnt;
  logic [SW-1:0]     set_cnt;
  // Running term index kept alongside the two counters so no multiply or
  // divide is needed to address the table.
  logic [AW-1:0]     term_cnt;

  logic signed [7:0] tab_a [N_TERM];
  logic signed [7:0] tab_b [N_TERM];
  logic signed [7:0] tab_c [N_TERM];
  logic signed [7:0] tab_d [N_TERM];
  logic signed [7:0] x_lat [N_IN];

  logic cfg_ok;
  logic last_set;
  logic last_term;

  // An entry is only legal if its breakpoints are ordered and the address
  // names a real term; the table is frozen while a sweep is using it.
  assign cfg_ok = (state == S_IDLE)
               && ({1'b0, cfg_addr} < (AW+1)'(N_TERM))
               && (cfg_a <= cfg_b) && (cfg_b <= cfg_c) && (cfg_c <= cfg_d);

  assign last_set  = (set_cnt == SW'(N_SET - 1));
  assign last_term = last_set && (in_cnt == IW'(N_IN - 1));

  always_comb begin
    tz_x = '0;
    tz_a = '0;
    tz_b = '0;
    tz_c = '0;
    tz_d = '0;
    if (state == S_RUN) begin
      tz_x = x_lat[in_cnt];
      tz_a = tab_a[term_cnt];
      tz_b = tab_b[term_cnt];
      tz_c = tab_c[term_cnt];
      tz_d = tab_d[term_cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_cnt   <= '0;
      set_cnt  <= '0;
      term_cnt <= '0;
      busy     <= 1'b0;
      mu_valid <= 1'b0;
      mu_idx   <= '0;
      mu_data  <= '0;
      done     <= 1'b0;
      cfg_drop <= 1'b0;
      for (int i = 0; i < N_TERM; i++) begin
        tab_a[i] <= '0;
        tab_b[i] <= '0;
        tab_c[i] <= '0;
        tab_d[i] <= '0;
      end
      for (int i = 0; i < N_IN; i++) begin
        x_lat[i] <= '0;
      end
    end else begin
      cfg_drop <= cfg_we && !cfg_ok;
      // The write lands on the same edge that samples start, so a sweep
      // started alongside a write already sees the new entry.
      if (cfg_we && cfg_ok) begin
        tab_a[cfg_addr] <= cfg_a;
        tab_b[cfg_addr] <= cfg_b;
        tab_c[cfg_addr] <= cfg_c;
        tab_d[cfg_addr] <= cfg_d;
      end

      mu_valid <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_IN; i++) begin
              x_lat[i] <= x_vec[8*i +: 8];
            end
            in_cnt   <= '0;
            set_cnt  <= '0;
            term_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          mu_data  <= tz_mu;
          mu_idx   <= term_cnt;
          mu_valid <= 1'b1;
          term_cnt <= term_cnt + 1'b1;
          if (last_term) begin
            // done is raised together with the last term's capture
            done  <= 1'b1;
            state <= S_DONE;
          end else if (last_set) begin
            set_cnt <= '0;
            in_cnt  <= in_cnt + 1'b1;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
